// File: rtl/gradient_magnitude_pipe_pkg.sv
// Shared types and helpers for the streaming gradient-magnitude pipeline.
package gradient_pkg;

    typedef enum logic {
        MAG_L1 = 1'b0,
        MAG_L2 = 1'b1
    } mag_mode_t;

    // Register stages from input acceptance to the output register.
    function automatic int mag_latency(input int out_w);
        return out_w + 4;
    endfunction

endpackage

// File: rtl/gradient_magnitude_pipe_isqrt_step.sv
// One registered restoring square-root step producing one root bit, MSB first.
// L1 samples pass straight through so both modes share the same latency.
module isqrt_step
    import gradient_pkg::*;
#(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  mag_mode_t       mode,
    input  logic [W+4:0]    rem_in,
    input  logic [W:0]      root_in,
    input  logic [2*W+1:0]  op_in,
    output logic [W+4:0]    rem_out,
    output logic [W:0]      root_out,
    output logic [2*W+1:0]  op_out
);

    localparam int RW = W + 5;

    logic [RW-1:0] rem_sh;
    logic [RW-1:0] trial;
    logic          fits;

    always_comb begin
        rem_sh = {rem_in[RW-3:0], op_in[2*W+1:2*W]};
        trial  = {2'b00, root_in, 2'b01};
        fits   = (rem_sh >= trial);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_out  <= '0;
            root_out <= '0;
            op_out   <= '0;
        end else if (en) begin
            if (mode == MAG_L1) begin
                rem_out  <= rem_in;
                root_out <= root_in;
                op_out   <= op_in;
            end else begin
                rem_out  <= fits ? (rem_sh - trial) : rem_sh;
                root_out <= {root_in[W-1:0], fits};
                op_out   <= {op_in[2*W-1:0], 2'b00};
            end
        end
    end

endmodule

// File: rtl/gradient_magnitude_pipe.sv
// Streaming Sobel gradient magnitude (L1 or L2 per sample) with saturation and edge flag.
// Fixed-latency pipeline under a single global stall driven by the output handshake.
module gradient_magnitude_pipe
    import gradient_pkg::*;
#(
    parameter int PRECISION = 16,
    parameter int OUT_W     = 8,
    parameter int USER_W    = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [PRECISION-1:0] vert_in,
    input  logic signed [PRECISION-1:0] horz_in,
    input  mag_mode_t                   mode,
    input  logic [USER_W-1:0]           user_in,
    input  logic [OUT_W-1:0]            thresh,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_W-1:0]            mag_out,
    output logic                        edge_out,
    output logic [USER_W-1:0]           user_out
);

    localparam int W     = OUT_W;
    localparam int NS    = W + 1;
    localparam int SW    = 2 * W + 2;
    localparam int RW    = W + 5;
    localparam int CHAIN = mag_latency(OUT_W) - 1;
    localparam logic [PRECISION:0] ONE_P = {{PRECISION{1'b0}}, 1'b1};

    logic adv;

    logic              valid_q [CHAIN];
    mag_mode_t         mode_q  [CHAIN];
    logic [USER_W-1:0] user_q  [CHAIN];

    logic [W-1:0]  av_q, ah_q;
    logic [SW-1:0] sum_q;

    logic [RW-1:0] rem_s  [NS+1];
    logic [W:0]    root_s [NS+1];
    logic [SW-1:0] op_s   [NS+1];

    logic [PRECISION:0] vx, hx, va, ha;
    logic [W-1:0]       av_c, ah_c;
    logic [SW-1:0]      avx, ahx, sum_c;
    logic [SW-1:0]      raw;
    logic [W-1:0]       mag_c;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Absolute value in P+1 bits so the most negative input maps to +2^(P-1) before clamping.
    always_comb begin
        vx   = {vert_in[PRECISION-1], vert_in};
        hx   = {horz_in[PRECISION-1], horz_in};
        va   = vx[PRECISION] ? (~vx + ONE_P) : vx;
        ha   = hx[PRECISION] ? (~hx + ONE_P) : hx;
        av_c = (|va[PRECISION:W]) ? {W{1'b1}} : va[W-1:0];
        ah_c = (|ha[PRECISION:W]) ? {W{1'b1}} : ha[W-1:0];
    end

    always_comb begin
        avx   = {{(SW-W){1'b0}}, av_q};
        ahx   = {{(SW-W){1'b0}}, ah_q};
        sum_c = (mode_q[0] == MAG_L2) ? (avx * avx + ahx * ahx) : (avx + ahx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHAIN; i++) begin
                valid_q[i] <= 1'b0;
                mode_q[i]  <= MAG_L1;
                user_q[i]  <= '0;
            end
            av_q  <= '0;
            ah_q  <= '0;
            sum_q <= '0;
        end else if (adv) begin
            valid_q[0] <= in_valid;
            mode_q[0]  <= mode;
            user_q[0]  <= user_in;
            for (int i = 1; i < CHAIN; i++) begin
                valid_q[i] <= valid_q[i-1];
                mode_q[i]  <= mode_q[i-1];
                user_q[i]  <= user_q[i-1];
            end
            av_q  <= av_c;
            ah_q  <= ah_c;
            sum_q <= sum_c;
        end
    end

    assign rem_s[0]  = '0;
    assign root_s[0] = '0;
    assign op_s[0]   = sum_q;

    // Step k consumes the sample held in pipeline stage k+1, so it follows that stage's mode.
    for (genvar k = 0; k < NS; k++) begin : g_sqrt
        isqrt_step #(.W(W)) u_step (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (adv),
            .mode     (mode_q[k+1]),
            .rem_in   (rem_s[k]),
            .root_in  (root_s[k]),
            .op_in    (op_s[k]),
            .rem_out  (rem_s[k+1]),
            .root_out (root_s[k+1]),
            .op_out   (op_s[k+1])
        );
    end

    always_comb begin
        raw   = (mode_q[CHAIN-1] == MAG_L2) ? {{(SW-W-1){1'b0}}, root_s[NS]} : op_s[NS];
        mag_c = (|raw[SW-1:W]) ? {W{1'b1}} : raw[W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            mag_out   <= '0;
            edge_out  <= 1'b0;
            user_out  <= '0;
        end else if (adv) begin
            out_valid <= valid_q[CHAIN-1];
            mag_out   <= mag_c;
            edge_out  <= (mag_c >= thresh);
            user_out  <= user_q[CHAIN-1];
        end
    end

endmodule
